// File: rtl/serial_adder.sv
// Bit-serial ripple adder: one full-adder step per clock, LSB first.
// Produces (a + b + cin) mod 2^WIDTH plus carry-out, WIDTH cycles after start.
module serial_adder #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic               c_q, c_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   sh_q, sh_d;
  logic [WIDTH-1:0]   sum_q, sum_d;
  logic               cout_q, cout_d;
  logic               done_q, done_d;

  logic               s_bit;
  logic               c_next;
  logic               last_bit;

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= 1'b0;
      cnt_q   <= '0;
      sh_q    <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      c_q     <= c_d;
      cnt_q   <= cnt_d;
      sh_q    <= sh_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      done_q  <= done_d;
    end
  end

  // Next-state and datapath logic
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    c_d      = c_q;
    cnt_d    = cnt_q;
    sh_d     = sh_q;
    sum_d    = sum_q;
    cout_d   = cout_q;
    done_d   = 1'b0;

    s_bit    = a_q[0] ^ b_q[0] ^ c_q;
    c_next   = (a_q[0] & b_q[0]) | (c_q & (a_q[0] ^ b_q[0]));
    last_bit = (cnt_q == CNT_W'(WIDTH - 1));

    case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          c_d     = cin;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        // Sum bits enter at the MSB so the LSB lands at bit 0 after WIDTH shifts
        sh_d  = (sh_q >> 1) | (WIDTH'(s_bit) << (WIDTH - 1));
        a_d   = a_q >> 1;
        b_d   = b_q >> 1;
        c_d   = c_next;
        cnt_d = cnt_q + CNT_W'(1);
        if (last_bit) begin
          sum_d   = sh_d;
          cout_d  = c_next;
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy = (state_q == RUN);
  assign done = done_q;
  assign sum  = sum_q;
  assign cout = cout_q;

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder (WIDTH = 8): directed cases plus
// randomized operations checked against an arithmetic reference model.
module tb_serial_adder;

  localparam int unsigned WIDTH = 8;

  logic             clk;
  logic             rst;
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;

  int n_tests = 0;
  int n_fail  = 0;
  int done_cnt = 0;
  int d0;

  logic [WIDTH-1:0] exp_sum;
  logic             exp_cout;

  serial_adder #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) if (done) done_cnt++;

  initial begin
    #5ms;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Start one addition, scramble inputs during RUN, optionally pulse start at RUN cycle inj
  task automatic do_op(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                       input logic ci, input int inj, input string tag);
    logic [WIDTH:0] ref_v;
    int lat;
    int bcnt;
    logic hold_ok;
    ref_v = (WIDTH+1)'(av) + (WIDTH+1)'(bv) + (WIDTH+1)'(ci);
    a = av; b = bv; cin = ci; start = 1'b1;
    step();
    start = 1'b0;
    lat = 0; bcnt = 0; hold_ok = 1'b1;
    while (!done && lat < 40) begin
      if (busy) bcnt++;
      if (sum !== exp_sum || cout !== exp_cout) hold_ok = 1'b0;
      a   = WIDTH'($urandom);
      b   = WIDTH'($urandom);
      cin = 1'($urandom);
      if (lat + 1 == inj) begin
        start = 1'b1; a = 8'hFF; b = 8'hFF; cin = 1'b1;
      end else begin
        start = 1'b0;
      end
      step();
      lat++;
    end
    start = 1'b0;
    check({tag, ".latency"}, 32'(lat), 32'(WIDTH));
    check({tag, ".busy_cycles"}, 32'(bcnt), 32'(WIDTH));
    check({tag, ".hold"}, 32'(hold_ok), 32'd1);
    check({tag, ".busy_at_done"}, 32'(busy), 32'd0);
    check({tag, ".sum"}, 32'(sum), 32'(ref_v[WIDTH-1:0]));
    check({tag, ".cout"}, 32'(cout), 32'(ref_v[WIDTH]));
    exp_sum  = ref_v[WIDTH-1:0];
    exp_cout = ref_v[WIDTH];
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
    exp_sum = '0; exp_cout = 1'b0;
    step();
    start = 1'b1;
    step();
    start = 1'b0;
    check("reset.busy", 32'(busy), 32'd0);
    check("reset.done", 32'(done), 32'd0);
    check("reset.sum",  32'(sum),  32'd0);
    check("reset.cout", 32'(cout), 32'd0);
    rst = 1'b0;
    step();

    // Basic addition and single done pulse
    d0 = done_cnt;
    do_op(8'h5A, 8'h3C, 1'b0, 0, "basic");
    check("basic.sum_const", 32'(sum), 32'h96);
    step();
    check("basic.done_low_after", 32'(done), 32'd0);
    check("basic.done_pulses", 32'(done_cnt - d0), 32'd1);

    // Carry boundaries, issued back-to-back
    do_op(8'hFF, 8'h01, 1'b0, 0, "ovf1");
    check("ovf1.const", 32'({cout, sum}), 32'h100);
    do_op(8'hFF, 8'hFF, 1'b1, 0, "ovf2");
    check("ovf2.const", 32'({cout, sum}), 32'h1FF);

    // Start during RUN is ignored
    step();
    d0 = done_cnt;
    do_op(8'h12, 8'h34, 1'b0, 3, "ignore");
    check("ignore.const", 32'({cout, sum}), 32'h046);
    repeat (3) step();
    check("ignore.done_pulses", 32'(done_cnt - d0), 32'd1);
    check("ignore.idle", 32'(busy), 32'd0);

    // Start in the done cycle; previous result held throughout the next RUN
    do_op(8'h5A, 8'h3C, 1'b0, 0, "b2b1");
    do_op(8'h80, 8'h80, 1'b0, 0, "b2b2");
    check("b2b2.const", 32'({cout, sum}), 32'h100);

    // Reset mid-RUN aborts without done
    step();
    a = 8'h77; b = 8'h11; cin = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    repeat (3) step();
    d0 = done_cnt;
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("abort.busy", 32'(busy), 32'd0);
    check("abort.sum",  32'(sum),  32'd0);
    check("abort.cout", 32'(cout), 32'd0);
    check("abort.done", 32'(done), 32'd0);
    exp_sum = '0; exp_cout = 1'b0;
    repeat (12) step();
    check("abort.no_done", 32'(done_cnt - d0), 32'd0);
    do_op(8'h01, 8'h02, 1'b0, 0, "after_rst");
    check("after_rst.const", 32'({cout, sum}), 32'h003);

    // Random operations against the arithmetic model
    for (int i = 0; i < 1000; i++) begin
      do_op(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom), 0, "rnd");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/serial_adder.md
SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 The module SHALL have parameter WIDTH, default 8, giving the operand and sum width in bits; legal range is WIDTH >= 1.
REQ-002 The module SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The module SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-004 The module SHALL have port start, input, 1 bit: request to begin an addition; sampled only when idle.
REQ-005 The module SHALL have port a, input, WIDTH bits: operand A, captured on an accepted start.
REQ-006 The module SHALL have port b, input, WIDTH bits: operand B, captured on an accepted start.
REQ-007 The module SHALL have port cin, input, 1 bit: carry-in, captured on an accepted start.
REQ-008 The module SHALL have port busy, output, 1 bit: high while an addition is in progress.
REQ-009 The module SHALL have port done, output, 1 bit: single-cycle pulse marking a new valid result.
REQ-010 The module SHALL have port sum, output, WIDTH bits: result (a + b + cin) mod 2^WIDTH.
REQ-011 The module SHALL have port cout, output, 1 bit: carry out of bit WIDTH-1.

Function
REQ-012 The module SHALL implement two states, IDLE and RUN, with busy = 1 exactly when the state is RUN.
REQ-013 In IDLE with start = 1 (edge E0), the module SHALL capture a, b and cin into internal registers, clear the bit counter to 0, and enter RUN.
REQ-014 In RUN, each rising edge SHALL process one bit, LSB first, using full-adder logic:
  - s_i = a_i ^ b_i ^ c
  - c_next = (a_i & b_i) | (c & (a_i ^ b_i))
  - c is the internal carry register.
REQ-015 On each RUN edge, the module SHALL shift s_i into an internal sum shift register from the MSB end, shift the operand registers right by one, update c, and increment the counter.
REQ-016 On the edge that processes bit WIDTH-1 (edge E_WIDTH), the module SHALL:
  - load sum from the completed shift register;
  - load cout from c_next;
  - assert done for exactly one cycle;
  - return to IDLE.
REQ-017 Latency SHALL be exactly WIDTH clock cycles from the start-sampling edge to the cycle in which done = 1 and the new sum/cout are visible.
REQ-018 sum and cout SHALL hold their last result unchanged from one completion until the next completion, including throughout a subsequent RUN.
REQ-019 start asserted while busy = 1 SHALL be ignored, with no effect on operands, counter or outputs.
REQ-020 start asserted in the cycle where done = 1 (state already IDLE) SHALL be accepted, giving back-to-back operations every WIDTH+1 cycles.
REQ-021 Changes on a, b or cin during RUN SHALL NOT affect the result in progress.
REQ-022 The bit counter SHALL be $clog2(WIDTH+1) bits wide and SHALL NOT wrap during a legal operation.
REQ-023 For WIDTH = 1, RUN SHALL last one cycle and done SHALL assert one cycle after start.

Reset
REQ-024 While rst = 1 on a rising edge, the module SHALL enter IDLE and drive busy = 0, done = 0, sum = 0, cout = 0, and clear the internal carry, counter and shift registers; rst SHALL take priority over start.
REQ-025 Reset asserted during RUN SHALL abort the operation with no done pulse; the first start after rst deasserts SHALL begin a fresh operation.

Verification (WIDTH = 8)
REQ-026 The bench SHALL apply start with a=0x5A, b=0x3C, cin=0 and check: busy high for 8 cycles; done pulses once in the 8th cycle after the start edge with sum=0x96, cout=0.
REQ-027 The bench SHALL apply a=0xFF, b=0x01, cin=0 and check sum=0x00, cout=1; then a=0xFF, b=0xFF, cin=1 and check sum=0xFF, cout=1.
REQ-028 The bench SHALL run a=0x12, b=0x34, then pulse start with a=0xFF, b=0xFF at cycle 3 of RUN, and check: second start ignored; result sum=0x46, cout=0; only one done pulse.
REQ-029 The bench SHALL assert start again in the done cycle with a=0x80, b=0x80, cin=0 and check: first result held until the second done; then sum=0x00, cout=1 exactly 8 cycles later.
REQ-030 The bench SHALL assert rst at cycle 4 of a RUN and check: busy=0, sum=0x00, cout=0 next cycle; no done pulse; a following a=0x01, b=0x02 start yields sum=0x03.
REQ-031 The bench SHALL run 1000 random a/b/cin operations against a reference model of (a + b + cin), checking sum and cout at every done pulse.
